// File: rtl/store_port_pkg.sv
// -----------------------------------------------------------------------------
// store_port_pkg
// Shared types and helpers for the store-side dcache write-port arbiter.
//   arb_state_e    : arbiter FSM states (IDLE / LOCKED)
//   store_req_t    : one requester's write payload, so the flat per-port
//                    buses can later collapse into an array of structs
//   port_id_width  : width of a port ID for a given number of requesters
//   wrap_inc       : circular increment of a port ID
// -----------------------------------------------------------------------------
package store_port_pkg;

  localparam int unsigned STORE_NR_PORTS        = 3;
  localparam int unsigned STORE_PLEN            = 56;
  localparam int unsigned STORE_DATA_WIDTH      = 64;
  localparam int unsigned STORE_MAX_OUTSTANDING = 4;
  localparam int unsigned STORE_PORT_ID_W       = $clog2(STORE_NR_PORTS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [STORE_PLEN-1:0]         addr;
    logic [STORE_DATA_WIDTH-1:0]   wdata;
    logic [STORE_DATA_WIDTH/8-1:0] be;
    logic [1:0]                    size;
  } store_req_t;

  // A single-port configuration still needs a 1-bit ID.
  function automatic int unsigned port_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/store_port_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// rr_port_fifo
// In-order ID FIFO. Records the requester ID of every accepted request so
// completions can be routed back in order. Reusable for load-side tracking.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i       : write data_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   data_i       : ID to record
//   head_o       : oldest entry
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
// -----------------------------------------------------------------------------
module rr_port_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // address bits coincide.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/store_port_arbiter.sv
// -----------------------------------------------------------------------------
// store_port_arbiter
// Shares one dcache write-request port between NR_PORTS store-side
// requesters. Round-robin selection, grant held stable (LOCKED) until the
// cache accepts, and in-order ack routing through an ID tracking FIFO.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_i/addr_i/wdata_i/be_i/size_i : per-port request and flat payload
//   gnt_o                : per-port grant (one-hot or zero)
//   ack_o                : per-port write acknowledge (one-hot or zero)
//   cache_req_o ... cache_size_o : muxed request towards the dcache
//   cache_gnt_i          : dcache accepts the current request
//   cache_ack_i          : dcache write completion, in request order
//   idle_o               : nothing requesting, locked or outstanding
//   err_o                : sticky protocol error (cleared only by reset)
// -----------------------------------------------------------------------------
module store_port_arbiter
  import store_port_pkg::*;
#(
  parameter int unsigned NR_PORTS        = STORE_NR_PORTS,
  parameter int unsigned PLEN            = STORE_PLEN,
  parameter int unsigned DATA_WIDTH      = STORE_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = STORE_MAX_OUTSTANDING
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_PORTS-1:0]              req_i,
  input  logic [NR_PORTS*PLEN-1:0]         addr_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NR_PORTS*2-1:0]            size_i,
  output logic [NR_PORTS-1:0]              gnt_o,
  output logic [NR_PORTS-1:0]              ack_o,
  output logic                             cache_req_o,
  output logic [PLEN-1:0]                  cache_addr_o,
  output logic [DATA_WIDTH-1:0]            cache_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          cache_be_o,
  output logic [1:0]                       cache_size_o,
  input  logic                             cache_gnt_i,
  input  logic                             cache_ack_i,
  output logic                             idle_o,
  output logic                             err_o
);

  localparam int unsigned IdW = port_id_width(NR_PORTS);
  localparam int unsigned BeW = DATA_WIDTH / 8;

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] lock_q, lock_d;
  logic           err_q, err_d;

  logic [IdW-1:0] sel;        // round-robin winner this cycle
  logic           found;      // at least one requester
  logic [IdW-1:0] cur;        // port currently driving the cache mux
  logic           cache_req;
  logic           gnt_fire;
  logic           lock_drop;
  logic           push, pop;
  logic           full, empty;
  logic [IdW-1:0] head;

  // First requesting port at or after rr_ptr_q, circularly.
  always_comb begin
    int unsigned idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NR_PORTS) idx = idx - NR_PORTS;
      if (!found && req_i[idx[IdW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    cur       = sel;
    cache_req = 1'b0;
    lock_drop = 1'b0;
    gnt_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        cur = sel;
        // Admission looks only at the registered fill level, so a pop in
        // the same cycle does not open a slot until the next cycle.
        if (found && !full) begin
          cache_req = 1'b1;
          if (!cache_gnt_i) begin
            lock_d  = sel;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        cur = lock_q;
        if (req_i[lock_q]) begin
          cache_req = 1'b1;
          if (cache_gnt_i) state_d = IDLE;
        end else begin
          // Requester withdrew before being granted: protocol violation.
          lock_drop = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_fire = cache_req & cache_gnt_i;
    if (gnt_fire) rr_ptr_d = IdW'(wrap_inc(32'(cur), NR_PORTS));
  end

  assign push  = gnt_fire;
  assign pop   = cache_ack_i & ~empty;
  assign err_d = err_q | lock_drop | (cache_ack_i & empty);

  rr_port_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cur),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      lock_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs are combinational, so they are forced low while reset
  // is asserted rather than waiting for the next edge.
  genvar gi;
  generate
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_port
      assign gnt_o[gi] = ~rst_i & gnt_fire & (cur == IdW'(gi));
      assign ack_o[gi] = ~rst_i & pop & (head == IdW'(gi));
    end
  endgenerate

  assign cache_req_o   = ~rst_i & cache_req;
  assign cache_addr_o  = addr_i[32'(cur)*PLEN +: PLEN];
  assign cache_wdata_o = wdata_i[32'(cur)*DATA_WIDTH +: DATA_WIDTH];
  assign cache_be_o    = be_i[32'(cur)*BeW +: BeW];
  assign cache_size_o  = size_i[32'(cur)*2 +: 2];

  assign idle_o = rst_i | ((state_q == IDLE) & ~|req_i & empty);
  assign err_o  = err_q;

endmodule

// File: tb/tb_store_port_arbiter.sv
module tb_store_port_arbiter;

  localparam int NP = 3;
  localparam int PL = 56;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_i;
  logic [NP*PL-1:0]  addr_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP*BW-1:0]  be_i;
  logic [NP*2-1:0]   size_i;
  logic [NP-1:0]     gnt_o;
  logic [NP-1:0]     ack_o;
  logic              cache_req_o;
  logic [PL-1:0]     cache_addr_o;
  logic [DW-1:0]     cache_wdata_o;
  logic [BW-1:0]     cache_be_o;
  logic [1:0]        cache_size_o;
  logic              cache_gnt_i;
  logic              cache_ack_i;
  logic              idle_o;
  logic              err_o;

  store_port_arbiter #(
    .NR_PORTS(NP), .PLEN(PL), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .be_i          (be_i),
    .size_i        (size_i),
    .gnt_o         (gnt_o),
    .ack_o         (ack_o),
    .cache_req_o   (cache_req_o),
    .cache_addr_o  (cache_addr_o),
    .cache_wdata_o (cache_wdata_o),
    .cache_be_o    (cache_be_o),
    .cache_size_o  (cache_size_o),
    .cache_gnt_i   (cache_gnt_i),
    .cache_ack_i   (cache_ack_i),
    .idle_o        (idle_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [PL-1:0] exp_addr [NP];
  logic [DW-1:0] exp_data [NP];
  logic [BW-1:0] exp_be   [NP];
  logic [1:0]    exp_size [NP];

  typedef struct {
    logic [2:0] req;
    logic       cgnt;
    logic       ack;
    logic [2:0] e_gnt;
    logic [2:0] e_ack;
    logic       e_creq;
    int         e_port;
    logic       e_idle;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] r, input logic g, input logic a);
    req_i       = r;
    cache_gnt_i = g;
    cache_ack_i = a;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},  64'(gnt_o), 64'd0);
    check({tag, "_ack"},  64'(ack_o), 64'd0);
    check({tag, "_creq"}, 64'(cache_req_o), 64'd0);
    check({tag, "_idle"}, 64'(idle_o), 64'd1);
    check({tag, "_err"},  64'(err_o), 64'd0);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      exp_addr[p] = 56'hAB_0000_0000_0000 | 56'((p + 1) * 'h40);
      exp_data[p] = 64'hDEAD_0000_0000_0000 + 64'(p);
      exp_be[p]   = 8'h0F << p;
      exp_size[p] = 2'(p);
      addr_i[p*PL +: PL]  = exp_addr[p];
      wdata_i[p*DW +: DW] = exp_data[p];
      be_i[p*BW +: BW]    = exp_be[p];
      size_i[p*2 +: 2]    = exp_size[p];
    end

    // Single port 0: same-cycle grant, ack two cycles later
    vecs[0]  = '{3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 0, 1'b0};
    vecs[1]  = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 0, 1'b0};
    vecs[2]  = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 0, 1'b0};
    vecs[3]  = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 0, 1'b1};
    // Port 2 alone brings the round-robin pointer back to 0
    vecs[4]  = '{3'b100, 1'b1, 1'b0, 3'b100, 3'b000, 1'b1, 2, 1'b0};
    // All ports, cache always grants, ack one cycle after each grant
    vecs[5]  = '{3'b111, 1'b1, 1'b1, 3'b001, 3'b100, 1'b1, 0, 1'b0};
    vecs[6]  = '{3'b111, 1'b1, 1'b1, 3'b010, 3'b001, 1'b1, 1, 1'b0};
    vecs[7]  = '{3'b111, 1'b1, 1'b1, 3'b100, 3'b010, 1'b1, 2, 1'b0};
    vecs[8]  = '{3'b111, 1'b1, 1'b1, 3'b001, 3'b100, 1'b1, 0, 1'b0};
    vecs[9]  = '{3'b111, 1'b1, 1'b1, 3'b010, 3'b001, 1'b1, 1, 1'b0};
    vecs[10] = '{3'b111, 1'b1, 1'b1, 3'b100, 3'b010, 1'b1, 2, 1'b0};
    vecs[11] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 0, 1'b0};
    // Port 1 locked for three cycles while port 0 also requests
    vecs[12] = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1, 1'b0};
    vecs[13] = '{3'b011, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1, 1'b0};
    vecs[14] = '{3'b011, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1, 1'b0};
    vecs[15] = '{3'b011, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1, 1'b0};
    vecs[16] = '{3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 0, 1'b0};
    vecs[17] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 0, 1'b0};
    vecs[18] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 0, 1'b0};
    vecs[19] = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 0, 1'b1};
    // Fill the tracking FIFO, fifth request blocked until after first ack
    vecs[20] = '{3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 0, 1'b0};
    vecs[21] = '{3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1, 1'b0};
    vecs[22] = '{3'b100, 1'b1, 1'b0, 3'b100, 3'b000, 1'b1, 2, 1'b0};
    vecs[23] = '{3'b001, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 0, 1'b0};
    vecs[24] = '{3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 0, 1'b0};
    vecs[25] = '{3'b010, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0, 0, 1'b0};
    vecs[26] = '{3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1, 1'b0};
    vecs[27] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 0, 1'b0};
    vecs[28] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 0, 1'b0};
    vecs[29] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 0, 1'b0};
    vecs[30] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 0, 1'b0};
    vecs[31] = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 0, 1'b1};

    // Reset with requests present: handshake outputs must stay low
    rst_i = 1'b1;
    drive(3'b111, 1'b1, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    drive(3'b000, 1'b0, 1'b0);
    rst_i = 1'b0;
    step();

    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].req, vecs[v].cgnt, vecs[v].ack);
      @(negedge clk_i);
      $display("vec %0d: req=%b cgnt=%b ack_in=%b -> gnt=%b ack=%b creq=%b idle=%b",
               v, req_i, cache_gnt_i, cache_ack_i, gnt_o, ack_o, cache_req_o, idle_o);
      check($sformatf("v%0d_gnt", v),  64'(gnt_o), 64'(vecs[v].e_gnt));
      check($sformatf("v%0d_ack", v),  64'(ack_o), 64'(vecs[v].e_ack));
      check($sformatf("v%0d_creq", v), 64'(cache_req_o), 64'(vecs[v].e_creq));
      check($sformatf("v%0d_idle", v), 64'(idle_o), 64'(vecs[v].e_idle));
      check($sformatf("v%0d_err", v),  64'(err_o), 64'd0);
      if (vecs[v].e_creq) begin
        check($sformatf("v%0d_addr", v),  64'(cache_addr_o),  64'(exp_addr[vecs[v].e_port]));
        check($sformatf("v%0d_wdata", v), cache_wdata_o,      exp_data[vecs[v].e_port]);
        check($sformatf("v%0d_be", v),    64'(cache_be_o),    64'(exp_be[vecs[v].e_port]));
        check($sformatf("v%0d_size", v),  64'(cache_size_o),  64'(exp_size[vecs[v].e_port]));
      end
      step();
    end

    // Ack with nothing outstanding
    drive(3'b000, 1'b0, 1'b1);
    @(negedge clk_i);
    $display("seq ack_empty: ack=%b", ack_o);
    check("ack_empty_no_ack", 64'(ack_o), 64'd0);
    step();
    drive(3'b000, 1'b0, 1'b0);
    check("ack_empty_err", 64'(err_o), 64'd1);
    step();
    step();
    check("ack_empty_err_sticky", 64'(err_o), 64'd1);

    rst_i = 1'b1;
    #1;
    check("err_cleared_by_reset", 64'(err_o), 64'd0);
    step();
    rst_i = 1'b0;
    step();

    // Port 2 drops its request while locked
    drive(3'b100, 1'b0, 1'b0);
    @(negedge clk_i);
    $display("seq lock_p2: creq=%b gnt=%b", cache_req_o, gnt_o);
    check("lock_p2_creq", 64'(cache_req_o), 64'd1);
    check("lock_p2_gnt", 64'(gnt_o), 64'd0);
    step();
    drive(3'b000, 1'b0, 1'b0);
    @(negedge clk_i);
    $display("seq drop_p2: gnt=%b ack=%b", gnt_o, ack_o);
    check("drop_gnt", 64'(gnt_o), 64'd0);
    check("drop_ack", 64'(ack_o), 64'd0);
    step();
    check("drop_err", 64'(err_o), 64'd1);
    drive(3'b001, 1'b1, 1'b0);
    @(negedge clk_i);
    $display("seq after_drop: gnt=%b", gnt_o);
    check("after_drop_gnt", 64'(gnt_o), 64'd1);
    step();
    drive(3'b000, 1'b0, 1'b1);
    @(negedge clk_i);
    check("after_drop_ack", 64'(ack_o), 64'd1);
    step();
    drive(3'b000, 1'b0, 1'b0);
    check("drop_err_sticky", 64'(err_o), 64'd1);

    // Reset with three outstanding and port 0 locked
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    drive(3'b001, 1'b1, 1'b0); step();
    drive(3'b010, 1'b1, 1'b0); step();
    drive(3'b100, 1'b1, 1'b0); step();
    drive(3'b001, 1'b0, 1'b0); step();
    $display("seq pre_reset: creq=%b gnt=%b idle=%b", cache_req_o, gnt_o, idle_o);
    check("pre_reset_locked_creq", 64'(cache_req_o), 64'd1);
    check("pre_reset_addr", 64'(cache_addr_o), 64'(exp_addr[0]));
    check("pre_reset_idle", 64'(idle_o), 64'd0);
    #2;
    rst_i       = 1'b1;
    cache_ack_i = 1'b1;
    #1;
    $display("seq midreset: gnt=%b ack=%b creq=%b idle=%b err=%b",
             gnt_o, ack_o, cache_req_o, idle_o, err_o);
    check_reset_outputs("midreset");
    cache_ack_i = 1'b0;
    step();
    rst_i = 1'b0;
    drive(3'b000, 1'b0, 1'b0);
    @(negedge clk_i);
    check("post_reset_idle", 64'(idle_o), 64'd1);
    step();
    drive(3'b000, 1'b0, 1'b1);
    @(negedge clk_i);
    $display("seq late_ack: ack=%b", ack_o);
    check("late_ack_no_ack", 64'(ack_o), 64'd0);
    step();
    drive(3'b000, 1'b0, 1'b0);
    check("late_ack_err", 64'(err_o), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
